// File: rtl/series_job_scheduler.sv
// Round-robin front end that shares one funcSelector series engine among NREQ requesters.
// Each accepted job is issued to the engine, guarded by a hang timeout, and returned with its requester id.
module series_job_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_x,
    input  logic [NREQ*2-1:0]    req_func,

    output logic                 fs_start,
    output logic [15:0]          fs_x,
    output logic [1:0]           fs_func,
    input  logic [17:0]          fs_r,
    input  logic                 fs_done,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [1:0]           rsp_func,
    output logic [17:0]          rsp_r,
    output logic                 rsp_err,

    output logic                 busy,
    output logic [7:0]           timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;

    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  id_q;
    logic [1:0]      job_func_q;
    logic [15:0]     fs_x_q;
    logic [1:0]      fs_func_q;
    logic [15:0]     wait_cnt_q;
    logic [17:0]     rsp_r_q;
    logic            rsp_err_q;
    logic [7:0]      timeout_cnt_q;
    logic            done_q;

    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    int              idx;
    logic [15:0]     x_arr    [NREQ];
    logic [1:0]      func_arr [NREQ];

    logic            done_edge;
    logic            wait_limit;
    logic            job_done;
    logic            job_timeout;

    // Unpack the operand buses so the granted lane can be picked with a narrow index.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            x_arr[k]    = req_x[16*k +: 16];
            func_arr[k] = req_func[2*k +: 2];
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDW'(idx);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign done_edge   = fs_done & ~done_q;
    assign wait_limit  = (wait_cnt_q == 16'(TIMEOUT - 1));
    assign job_done    = (state_q == S_WAIT) && done_edge;
    assign job_timeout = (state_q == S_WAIT) && !done_edge && wait_limit;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (job_done || job_timeout) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; response fields read as zero outside RESP.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
        fs_start    = (state_q == S_ISSUE);
        fs_x        = fs_x_q;
        fs_func     = fs_func_q;
        rsp_valid   = (state_q == S_RESP);
        rsp_id      = rsp_valid ? id_q       : '0;
        rsp_func    = rsp_valid ? job_func_q : 2'd0;
        rsp_r       = rsp_valid ? rsp_r_q    : 18'd0;
        rsp_err     = rsp_valid ? rsp_err_q  : 1'b0;
        busy        = (state_q != S_IDLE);
        timeout_cnt = timeout_cnt_q;
    end

    // Job datapath: operand latch, wait counter, result capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            id_q          <= '0;
            job_func_q    <= 2'd0;
            fs_x_q        <= 16'd0;
            fs_func_q     <= 2'd0;
            wait_cnt_q    <= 16'd0;
            rsp_r_q       <= 18'd0;
            rsp_err_q     <= 1'b0;
            timeout_cnt_q <= 8'd0;
            done_q        <= 1'b0;
        end else begin
            done_q <= fs_done;
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        id_q       <= grant_idx;
                        job_func_q <= func_arr[grant_idx];
                        fs_x_q     <= x_arr[grant_idx];
                        fs_func_q  <= func_arr[grant_idx];
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= 16'd0;
                end
                S_WAIT: begin
                    // A done edge on the limit cycle still counts as a normal completion.
                    if (job_done) begin
                        rsp_r_q   <= fs_r;
                        rsp_err_q <= 1'b0;
                        fs_x_q    <= 16'd0;
                        fs_func_q <= 2'd0;
                    end else if (job_timeout) begin
                        rsp_r_q   <= 18'd0;
                        rsp_err_q <= 1'b1;
                        fs_x_q    <= 16'd0;
                        fs_func_q <= 2'd0;
                        if (timeout_cnt_q != 8'hFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_series_job_scheduler.sv
// Directed bench for series_job_scheduler: a table of single jobs plus hand-written
// sequences for timeout, response back-pressure, stale done level and reset in WAIT.
module tb_series_job_scheduler;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [63:0]  req_x;
    logic [7:0]   req_func;
    logic         fs_start;
    logic [15:0]  fs_x;
    logic [1:0]   fs_func;
    logic [17:0]  fs_r;
    logic         fs_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [1:0]   rsp_func;
    logic [17:0]  rsp_r;
    logic         rsp_err;
    logic         busy;
    logic [7:0]   timeout_cnt;

    int checks = 0;
    int errors = 0;

    series_job_scheduler #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_func   (req_func),
        .fs_start   (fs_start),
        .fs_x       (fs_x),
        .fs_func    (fs_func),
        .fs_r       (fs_r),
        .fs_done    (fs_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_func   (rsp_func),
        .rsp_r      (rsp_r),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .timeout_cnt(timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          rst_first;
        logic [3:0]  mask;
        logic [63:0] xs;
        logic [7:0]  funcs;
        int          lat;
        logic [17:0] r;
        int          exp_id;
        logic [1:0]  exp_func;
        logic [15:0] exp_x;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0;
        fs_done   = 1'b0;
        fs_r      = 18'd0;
        rsp_ready = 1'b0;
        cyc();
        rst       = 1'b0;
    endtask

    // Drives one job from the IDLE handshake up to the RESP cycle; engine done is raised lat cycles after fs_start.
    task automatic job_to_resp(input logic [3:0] mask, input logic [63:0] xs, input logic [7:0] funcs,
                               input int lat, input logic [17:0] r, input int exp_id,
                               input logic [1:0] exp_func, input logic [15:0] exp_x, input bit keep_done);
        int stray;
        req_valid = mask;
        req_x     = xs;
        req_func  = funcs;
        #1;
        check("grant", req_ready, 32'd1 << exp_id);
        cyc();
        check("issue_start", fs_start, 1);
        check("issue_fs_x", fs_x, exp_x);
        check("issue_fs_func", fs_func, exp_func);
        stray = 0;
        for (int k = 1; k <= lat; k++) begin
            cyc();
            if (fs_start || req_ready != 4'b0 || rsp_valid || fs_x !== exp_x) stray++;
        end
        check("wait_quiet", stray, 0);
        fs_done = 1'b1;
        fs_r    = r;
        cyc();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, exp_id);
        check("rsp_func", rsp_func, exp_func);
        check("rsp_r", rsp_r, r);
        check("rsp_err", rsp_err, 0);
        check("rsp_fs_x_clear", fs_x, 0);
        if (!keep_done) fs_done = 1'b0;
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("idle_not_busy", busy, 0);
    endtask

    initial begin
        int bad;

        // Req 0 basic job, then grant rotation with all four requesting, then pointer/boundary cases.
        vecs[0] = '{1'b0, 4'b0001, 64'h0000_0000_0000_0001, 8'h00, 5,  18'h00ABC, 0, 2'd0, 16'h0001};
        vecs[1] = '{1'b1, 4'b1111, 64'h4444_3333_2222_1111, 8'hE4, 3,  18'h10001, 0, 2'd0, 16'h1111};
        vecs[2] = '{1'b0, 4'b1111, 64'h4444_3333_2222_1111, 8'hE4, 4,  18'h20002, 1, 2'd1, 16'h2222};
        vecs[3] = '{1'b0, 4'b1111, 64'h4444_3333_2222_1111, 8'hE4, 2,  18'h30003, 2, 2'd2, 16'h3333};
        vecs[4] = '{1'b0, 4'b1111, 64'h4444_3333_2222_1111, 8'hE4, 6,  18'h3FFFF, 3, 2'd3, 16'h4444};
        vecs[5] = '{1'b0, 4'b1111, 64'h4444_3333_2222_1111, 8'hE4, 1,  18'h00005, 0, 2'd0, 16'h1111};
        vecs[6] = '{1'b0, 4'b1111, 64'h4444_3333_2222_1111, 8'hE4, 7,  18'h12345, 1, 2'd1, 16'h2222};
        vecs[7] = '{1'b0, 4'b1010, 64'hDEAD_BEEF_CAFE_F00D, 8'h1B, 15, 18'h2AAAA, 3, 2'd0, 16'hDEAD};
        vecs[8] = '{1'b0, 4'b0110, 64'hDEAD_BEEF_CAFE_F00D, 8'h1B, 16, 18'h15555, 1, 2'd2, 16'hCAFE};
        vecs[9] = '{1'b0, 4'b0001, 64'hDEAD_BEEF_CAFE_F00D, 8'h1B, 1,  18'h00001, 0, 2'd3, 16'hF00D};

        rst       = 1'b1;
        req_valid = 4'b0;
        req_x     = 64'd0;
        req_func  = 8'd0;
        fs_r      = 18'd0;
        fs_done   = 1'b0;
        rsp_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_fs_start", fs_start, 0);
        check("reset_fs_x", fs_x, 0);
        check("reset_fs_func", fs_func, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_fields", {rsp_id, rsp_func, rsp_r, rsp_err}, 0);
        check("reset_busy", busy, 0);
        check("reset_timeout_cnt", timeout_cnt, 0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst_first) do_reset();
            job_to_resp(vecs[i].mask, vecs[i].xs, vecs[i].funcs, vecs[i].lat, vecs[i].r,
                        vecs[i].exp_id, vecs[i].exp_func, vecs[i].exp_x, 1'b0);
            accept();
        end

        // Timeout: engine never answers, response after 16 WAIT cycles; a late done is ignored.
        req_valid = 4'b0100;
        req_x     = 64'h0000_0BEE_0000_0000;
        req_func  = 8'h10;
        #1;
        check("to_grant", req_ready, 4'b0100);
        cyc();
        req_valid = 4'b0;
        check("to_start", fs_start, 1);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (rsp_valid) bad++;
        end
        check("to_no_early_rsp", bad, 0);
        cyc();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_r", rsp_r, 0);
        check("to_rsp_id", rsp_id, 2);
        check("to_rsp_func", rsp_func, 1);
        check("to_count", timeout_cnt, 1);
        check("to_fs_x_clear", fs_x, 0);
        accept();
        cyc();
        cyc();
        fs_done = 1'b1;
        fs_r    = 18'h3FFFF;
        cyc();
        fs_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (rsp_valid || busy) bad++;
        end
        check("to_late_done_ignored", bad, 0);
        check("to_count_hold", timeout_cnt, 1);

        // Back-pressure: response held 10 cycles while req 1 waits.
        job_to_resp(4'b0001, 64'h0000_0000_0000_7777, 8'h02, 3, 18'h2BEEF, 0, 2'd2, 16'h7777, 1'b0);
        req_valid = 4'b0011;
        req_x     = 64'h0000_0000_8888_7777;
        req_func  = 8'h0E;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!rsp_valid || rsp_id !== 2'd0 || rsp_func !== 2'd2 || rsp_r !== 18'h2BEEF ||
                rsp_err || req_ready !== 4'b0 || fs_start) bad++;
            cyc();
        end
        check("bp_stable", bad, 0);
        accept();
        job_to_resp(4'b0011, 64'h0000_0000_8888_7777, 8'h0E, 2, 18'h01111, 1, 2'd3, 16'h8888, 1'b0);
        accept();

        // Stale done level: fs_done stays high from the previous job into the next one.
        job_to_resp(4'b0001, 64'h0000_0000_0000_0042, 8'h00, 2, 18'h00777, 0, 2'd0, 16'h0042, 1'b1);
        accept();
        req_valid = 4'b0010;
        req_x     = 64'h0000_0000_0099_0000;
        req_func  = 8'h04;
        #1;
        check("stale_grant", req_ready, 4'b0010);
        cyc();
        req_valid = 4'b0;
        check("stale_start", fs_start, 1);
        check("stale_fs_x", fs_x, 16'h0099);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (rsp_valid) bad++;
        end
        fs_done = 1'b0;
        cyc();
        if (rsp_valid) bad++;
        check("stale_no_complete", bad, 0);
        fs_done = 1'b1;
        fs_r    = 18'h12345;
        cyc();
        check("stale_rsp_valid", rsp_valid, 1);
        check("stale_rsp_r", rsp_r, 18'h12345);
        check("stale_rsp_id", rsp_id, 1);
        check("stale_rsp_err", rsp_err, 0);
        fs_done = 1'b0;
        accept();

        // Reset in WAIT: job dropped silently, later done produces nothing, pointer restarts at 0.
        req_valid = 4'b1000;
        req_x     = 64'h5A5A_0000_0000_0000;
        req_func  = 8'h80;
        #1;
        check("rw_grant", req_ready, 4'b1000);
        cyc();
        req_valid = 4'b0;
        cyc();
        cyc();
        check("rw_in_wait", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rw_busy", busy, 0);
        check("rw_outputs", {req_ready, fs_start, fs_x, fs_func, rsp_valid, rsp_id, rsp_func, rsp_r, rsp_err}, 0);
        check("rw_timeout_cnt", timeout_cnt, 0);
        fs_done = 1'b1;
        fs_r    = 18'h0F0F0;
        cyc();
        fs_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (rsp_valid || busy) bad++;
        end
        check("rw_no_response", bad, 0);
        job_to_resp(4'b1111, 64'h4444_3333_2222_1111, 8'hE4, 2, 18'h00F0F, 0, 2'd0, 16'h1111, 1'b0);
        accept();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
